// File: rtl/freq_bcd_to_bin_pkg.sv
// rtl/freq_bcd_to_bin_pkg.sv - shared widths, limits and FSM states for the BCD-to-binary frequency converter
// Contents: result/BCD widths, shift count, saturation value, digit widths, FSM state type.
package freq_pkg;

  localparam int BIN_W   = 12;
  localparam int BCD_W   = 15;
  localparam int N_SHIFT = 12;
  localparam int THOU_W  = 3;
  localparam int DIG_W   = 4;
  localparam int CNT_W   = 4;

  localparam logic [BIN_W-1:0] FREQ_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A 4-bit digit field is illegal BCD when it holds 10..15.
  function automatic logic digit_invalid(input logic [DIG_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/freq_bcd_to_bin_if.sv
// rtl/freq_bcd_to_bin_if.sv - request/result bundle between digit-entry logic and the converter
// Signals: start, thousand[2:0], hundred/ten/one[3:0] (requester -> converter);
//          busy, done, data_out[11:0], err (converter -> requester).
// Modports: master = requester, slave = converter.
interface freq_bcd_to_bin_if
  import freq_pkg::*;
();

  logic              start;
  logic [THOU_W-1:0] thousand;
  logic [DIG_W-1:0]  hundred;
  logic [DIG_W-1:0]  ten;
  logic [DIG_W-1:0]  one;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  data_out;
  logic              err;

  modport master (
    output start, thousand, hundred, ten, one,
    input  busy, done, data_out, err
  );

  modport slave (
    input  start, thousand, hundred, ten, one,
    output busy, done, data_out, err
  );

endinterface

// File: rtl/freq_bcd_to_bin_digit_adj.sv
// rtl/freq_bcd_to_bin_digit_adj.sv - reverse double-dabble digit correction
// Ports: din[3:0] digit after the right shift, dout[3:0] corrected digit.
// A digit >= 8 after shifting received a carried-in 8 that is really 5 (10/2), so subtract 3.
module bcd_digit_adj
  import freq_pkg::*;
(
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/freq_bcd_to_bin.sv
// rtl/freq_bcd_to_bin.sv - iterative 4-digit BCD to 12-bit binary converter with start/busy/done handshake
// Ports: clk, rst_n (async active-low), bus (freq_bcd_to_bin_if.slave):
//        start/thousand/hundred/ten/one in; busy/done/data_out/err out, all registered.
module freq_bcd_to_bin
  import freq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  freq_bcd_to_bin_if.slave     bus
);

  state_t             state;
  logic [BCD_W-1:0]   bcd;
  logic [BIN_W-1:0]   bin;
  logic [CNT_W-1:0]   count;
  logic               busy_q;
  logic               done_q;
  logic [BIN_W-1:0]   data_q;
  logic               err_q;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       sh_bcd;
  logic [BIN_W-1:0]       sh_bin;
  logic [DIG_W-1:0]       adj_h;
  logic [DIG_W-1:0]       adj_t;
  logic [DIG_W-1:0]       adj_o;
  logic [BCD_W-1:0]       nxt_bcd;
  logic                   in_invalid;
  logic                   last_shift;

  // One step: shift {bcd, bin} right, then correct the three 4-bit digits.
  assign shifted = {bcd, bin} >> 1;
  assign sh_bcd  = shifted[BCD_W+BIN_W-1:BIN_W];
  assign sh_bin  = shifted[BIN_W-1:0];

  bcd_digit_adj u_adj_h (.din(sh_bcd[11:8]), .dout(adj_h));
  bcd_digit_adj u_adj_t (.din(sh_bcd[7:4]),  .dout(adj_t));
  bcd_digit_adj u_adj_o (.din(sh_bcd[3:0]),  .dout(adj_o));

  // The thousand field's top bit is zero after a shift, so it never reaches 8.
  assign nxt_bcd = {sh_bcd[14:12], adj_h, adj_t, adj_o};

  // A thousand of 5..7 is not flagged here; it leaves a nonzero residue instead.
  assign in_invalid = digit_invalid(bus.hundred) | digit_invalid(bus.ten) |
                      digit_invalid(bus.one);

  assign last_shift = (count == CNT_W'(N_SHIFT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bcd    <= '0;
      bin    <= '0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bcd   <= {bus.thousand, bus.hundred, bus.ten, bus.one};
            bin   <= '0;
            count <= '0;
            if (in_invalid) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              data_q <= '0;
              err_q  <= 1'b1;
            end else begin
              state  <= ST_SHIFT;
              busy_q <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          bcd   <= nxt_bcd;
          bin   <= sh_bin;
          count <= count + 1'b1;
          // Result is registered on the final shift so done and data_out appear together.
          if (last_shift) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (nxt_bcd != '0) begin
              data_q <= FREQ_MAX;
              err_q  <= 1'b1;
            end else begin
              data_q <= sh_bin;
              err_q  <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;
  assign bus.err      = err_q;

endmodule
